// File: rtl/dsp_mul_acc_round_sat.sv
// Frame accumulator behind the signed DSP multiplier. It sums frame_len products,
// then rounds, right-shifts and saturates the sum into one strobed output word.
module dsp_mul_acc_round_sat #(
    parameter int P_WIDTH   = 65,
    parameter int CNT_WIDTH = 8,
    parameter int ACC_WIDTH = 73,
    parameter int SHIFT     = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic [P_WIDTH-1:0]   p_in,
    input  logic                 p_valid,
    input  logic [CNT_WIDTH-1:0] frame_len,
    output logic [OUT_WIDTH-1:0] y,
    output logic                 y_valid,
    output logic                 y_ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Half an output LSB, added before the shift; SHIFT == 0 means no rounding.
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_WIDTH:0] RND =
        (SHIFT > 0) ? ((ACC_WIDTH + 1)'(1) << RND_POS) : '0;
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN =
        {{(ACC_WIDTH + 2 - OUT_WIDTH){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    state_t state;
    state_t state_next;

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] p_ext;
    logic        [CNT_WIDTH-1:0] cnt;
    logic        [CNT_WIDTH-1:0] cnt_inc;
    logic        [CNT_WIDTH-1:0] len;
    logic        [CNT_WIDTH-1:0] len_in;
    logic                        start;
    logic                        accum;

    logic signed [ACC_WIDTH:0]   acc_wide;
    logic signed [ACC_WIDTH:0]   rounded;
    logic        [OUT_WIDTH-1:0] y_next;
    logic                        ovf_next;

    assign p_ext   = {{(ACC_WIDTH - P_WIDTH){p_in[P_WIDTH-1]}}, p_in};
    assign len_in  = (frame_len == '0) ? CNT_WIDTH'(1) : frame_len;
    assign cnt_inc = cnt + CNT_WIDTH'(1);

    // A product seen in OUT opens the next frame, so the block never needs a bubble.
    assign start = p_valid && (state != ACC);
    assign accum = p_valid && (state == ACC);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal written in a combinational block gets a default first,
        // otherwise a path that skips the assignment infers a latch.
        state_next = state;
        case (state)
            IDLE, OUT: begin
                if (p_valid) begin
                    state_next = (len_in == CNT_WIDTH'(1)) ? OUT : ACC;
                end else begin
                    state_next = IDLE;
                end
            end
            ACC: begin
                if (p_valid && (cnt_inc == len)) begin
                    state_next = OUT;
                end
            end
            default: state_next = IDLE;
        endcase
        if (clr) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // One extra bit keeps the rounding add from wrapping at the top of the range.
    always_comb begin
        acc_wide = {acc[ACC_WIDTH-1], acc};
        rounded  = (acc_wide + RND) >>> SHIFT;
        y_next   = rounded[OUT_WIDTH-1:0];
        ovf_next = 1'b0;
        if (rounded > OUT_MAX) begin
            y_next   = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
            ovf_next = 1'b1;
        end else if (rounded < OUT_MIN) begin
            y_next   = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
            ovf_next = 1'b1;
        end
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            len     <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            y_ovf   <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            cnt     <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= 1'b0;
            if (state == OUT) begin
                y       <= y_next;
                y_ovf   <= ovf_next;
                y_valid <= 1'b1;
            end
            if (start) begin
                acc <= p_ext;
                cnt <= CNT_WIDTH'(1);
                len <= len_in;
            end else if (accum) begin
                acc <= acc + p_ext;
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mul_acc_round_sat.sv
// Self-checking bench: directed cases plus random frames, compared every cycle against
// a frame-level arithmetic model of the accumulator.
module tb_dsp_mul_acc_round_sat;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic [64:0] p_in;
    logic        p_valid;
    logic [7:0]  frame_len;
    logic [31:0] y;
    logic        y_valid;
    logic        y_ovf;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    // Frame-level reference model state
    bit                  m_in_frame = 0;
    bit                  m_pend = 0;
    logic signed [127:0] m_sum = '0;
    logic signed [127:0] m_pend_sum = '0;
    int                  m_n = 0;
    int                  m_len = 1;
    logic [31:0]         m_y = '0;
    logic                m_ovf = 1'b0;
    logic                m_y_valid = 1'b0;
    logic                m_busy = 1'b0;

    dsp_mul_acc_round_sat dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .p_in      (p_in),
        .p_valid   (p_valid),
        .frame_len (frame_len),
        .y         (y),
        .y_valid   (y_valid),
        .y_ovf     (y_ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Round half toward +inf at 16 fraction bits, then clip to signed 32 bits.
    task automatic round_sat(input logic signed [127:0] s, output logic [31:0] yy, output logic o);
        logic signed [127:0] r;
        r = (s + 128'sd32768) >>> 16;
        if (r > 128'sd2147483647) begin
            yy = 32'h7FFF_FFFF;
            o  = 1'b1;
        end else if (r < -128'sd2147483648) begin
            yy = 32'h8000_0000;
            o  = 1'b1;
        end else begin
            yy = r[31:0];
            o  = 1'b0;
        end
    endtask

    task automatic model_edge(input logic r, input logic c, input logic v,
                              input logic [64:0] p, input logic [7:0] fl);
        logic signed [127:0] pe;
        pe = {{63{p[64]}}, p};
        m_y_valid = 1'b0;
        if (m_pend && !r && !c) begin
            round_sat(m_pend_sum, m_y, m_ovf);
            m_y_valid = 1'b1;
        end
        m_pend = 0;
        if (r) begin
            m_y        = '0;
            m_ovf      = 1'b0;
            m_in_frame = 0;
        end else if (c) begin
            m_in_frame = 0;
        end else if (v) begin
            if (!m_in_frame) begin
                m_sum = pe;
                m_n   = 1;
                m_len = (fl == 0) ? 1 : int'(fl);
            end else begin
                m_sum = m_sum + pe;
                m_n++;
            end
            if (m_n == m_len) begin
                m_pend     = 1;
                m_pend_sum = m_sum;
                m_in_frame = 0;
            end else begin
                m_in_frame = 1;
            end
        end
        m_busy = m_in_frame || m_pend;
    endtask

    task automatic step(input logic r, input logic c, input logic v,
                        input logic [64:0] p, input logic [7:0] fl);
        reset     = r;
        clr       = c;
        p_valid   = v;
        p_in      = p;
        frame_len = fl;
        @(posedge clk);
        model_edge(r, c, v, p, fl);
        #1;
        check("y_valid", 32'(y_valid), 32'(m_y_valid));
        check("busy", 32'(busy), 32'(m_busy));
        check("y", y, m_y);
        check("y_ovf", 32'(y_ovf), 32'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 65'd0, 8'd0);
    endtask

    task automatic prod(input logic [64:0] p, input logic [7:0] fl);
        step(1'b0, 1'b0, 1'b1, p, fl);
    endtask

    // Independent constant expectations for the directed cases.
    task automatic expect_result(input string tag, input logic [31:0] ey, input logic eo);
        check({tag, "_valid"}, 32'(y_valid), 32'd1);
        check(tag, y, ey);
        check({tag, "_ovf"}, 32'(y_ovf), 32'(eo));
    endtask

    initial begin
        logic [95:0] rr;
        logic [64:0] rp;
        logic        rc;
        logic        rv;
        logic        rs;

        reset = 1'b1; clr = 1'b0; p_valid = 1'b1; p_in = 65'd100; frame_len = 8'd1;

        // Reset dominates a valid product
        step(1'b1, 1'b0, 1'b1, 65'd100, 8'd1);
        step(1'b1, 1'b0, 1'b1, 65'd100, 8'd1);
        check("rst_y", y, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(y_valid), 32'd0);
        prod(65'd65536, 8'd1);
        idle(1);
        expect_result("post_rst", 32'd1, 1'b0);
        idle(1);

        // Frame sum, contiguous and with gaps
        prod(65'd327680, 8'd4);
        prod(65'd131072, 8'd4);
        prod(-65'sd65536, 8'd4);
        prod(65'd262144, 8'd4);
        idle(1);
        expect_result("sum4", 32'd10, 1'b0);
        idle(1);
        prod(65'd327680, 8'd4);  idle(3);
        prod(65'd131072, 8'd9);  idle(3);
        prod(-65'sd65536, 8'd0); idle(3);
        prod(65'd262144, 8'd1);
        idle(1);
        expect_result("sum4_gaps", 32'd10, 1'b0);
        idle(1);

        // Rounding ties and just-below-tie cases
        prod(65'h18000, 8'd1);     idle(1); expect_result("rnd_p15", 32'd2, 1'b0);
        prod(65'h17FFF, 8'd1);     idle(1); expect_result("rnd_p1", 32'd1, 1'b0);
        prod(-65'sd98304, 8'd1);   idle(1); expect_result("rnd_m15", 32'hFFFF_FFFF, 1'b0);
        prod(-65'sd98305, 8'd1);   idle(1); expect_result("rnd_m2", 32'hFFFF_FFFE, 1'b0);

        // Saturation at both rails, then recovery; frame_len 0 acts as 1
        prod(65'h0_4000_0000_0000_0000, 8'd2);
        prod(65'h0_4000_0000_0000_0000, 8'd2);
        idle(1); expect_result("sat_pos", 32'h7FFF_FFFF, 1'b1);
        prod(65'h1_C000_0000_0000_0000, 8'd2);
        prod(65'h1_C000_0000_0000_0000, 8'd2);
        idle(1); expect_result("sat_neg", 32'h8000_0000, 1'b1);
        prod(65'd65536, 8'd0);
        idle(1); expect_result("sat_clear", 32'd1, 1'b0);
        idle(1);

        // Back-to-back single-product frames, then a 2-product frame opened in OUT
        prod(65'd65536, 8'd1);
        prod(65'd131072, 8'd1);  expect_result("b2b_1", 32'd1, 1'b0);
        prod(65'd196608, 8'd1);  expect_result("b2b_2", 32'd2, 1'b0);
        prod(65'd262144, 8'd2);  expect_result("b2b_3", 32'd3, 1'b0);
        prod(65'd327680, 8'd1);
        check("b2b_gap", 32'(y_valid), 32'd0);
        idle(1); expect_result("b2b_len2", 32'd9, 1'b0);
        idle(1);

        // Abort by clr, and by reset, in the middle of a frame
        prod(65'd458752, 8'd4);
        prod(65'd458752, 8'd4);
        step(1'b0, 1'b1, 1'b1, 65'd458752, 8'd4);
        for (int i = 0; i < 4; i++) prod(65'd65536, 8'd4);
        idle(1); expect_result("abort_clr", 32'd4, 1'b0);
        idle(1);
        prod(65'd458752, 8'd4);
        prod(65'd458752, 8'd4);
        step(1'b1, 1'b0, 1'b1, 65'd458752, 8'd4);
        check("abort_rst_y", y, 32'd0);
        for (int i = 0; i < 4; i++) prod(65'd65536, 8'd4);
        idle(1); expect_result("abort_rst", 32'd4, 1'b0);
        // clr in the OUT cycle suppresses the result
        prod(65'd65536, 8'd1);
        step(1'b0, 1'b1, 1'b0, 65'd0, 8'd1);
        check("clr_out_sup", 32'(y_valid), 32'd0);
        idle(2);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rr = {$urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       rp = rr[64:0];
                1:       rp = {{25{rr[39]}}, rr[39:0]};
                default: rp = {{41{rr[23]}}, rr[23:0]};
            endcase
            rv = ($urandom_range(0, 9) < 7);
            rc = ($urandom_range(0, 79) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(rs, rc, rv, rp, 8'($urandom_range(0, 6)));
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
